// File: rtl/fir_cfg_pkg.sv
// +--------------------------------------------------------------------------+
// | fir_cfg_pkg : shared types and register map for the FIR config loader    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package fir_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_LEN = 3'd1,
    S_WR_TAP = 3'd2,
    S_RD_TAP = 3'd3,
    S_WR_AP  = 3'd4,
    S_POLL   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_LEN      = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  localparam logic [3:0] ERR_TIMEOUT = 4'hF;

  function automatic int tap_addr(input logic [3:0] k);
    return ADDR_TAP_BASE + 4 * int'(k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_cfg_loader_xact.sv
// +--------------------------------------------------------------------------+
// | axil_master_xact : one AXI-Lite read or write per req, ack on completion |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module axil_master_xact #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   ack,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [pADDR_WIDTH-1:0] axi_awaddr,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  output logic [pDATA_WIDTH-1:0] axi_wdata,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  output logic [pADDR_WIDTH-1:0] axi_araddr,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,
  input  logic [pDATA_WIDTH-1:0] axi_rdata
);

  logic                   r_busy, r_we;
  logic                   r_awvalid, r_wvalid, r_aw_done, r_w_done;
  logic                   r_arvalid, r_rready;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [pDATA_WIDTH-1:0] r_wdata, r_rdata;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_wr_ack, w_rd_ack;

  assign w_aw_hs = r_awvalid & axi_awready;
  assign w_w_hs  = r_wvalid  & axi_wready;
  assign w_ar_hs = r_arvalid & axi_arready;
  assign w_r_hs  = r_rready  & axi_rvalid;

  // Ack is combinational so the sequencer can advance on the completing edge.
  assign w_wr_ack = r_busy & r_we & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_rd_ack = r_busy & ~r_we & w_r_hs;
  assign ack      = w_wr_ack | w_rd_ack;
  assign rdata    = w_r_hs ? axi_rdata : r_rdata;

  assign axi_awvalid = r_awvalid;
  assign axi_wvalid  = r_wvalid;
  assign axi_arvalid = r_arvalid;
  assign axi_rready  = r_rready;
  assign axi_awaddr  = r_addr;
  assign axi_araddr  = r_addr;
  assign axi_wdata   = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else if (!r_busy) begin
      if (req) begin
        r_busy    <= 1'b1;
        r_we      <= we;
        r_addr    <= addr;
        r_wdata   <= wdata;
        r_awvalid <= we;
        r_wvalid  <= we;
        r_arvalid <= ~we;
      end
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_r_hs) begin
        r_rready <= 1'b0;
        r_rdata  <= axi_rdata;
      end
      if (ack) begin
        r_busy    <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_cfg_loader.sv
// +--------------------------------------------------------------------------+
// | fir_cfg_loader : programs, verifies and starts the FIR over AXI-Lite     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_cfg_loader
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_MAX    = 1000000
) (
  input  logic                            axis_clk,
  input  logic                            axis_rst_n,
  input  logic                            start,
  input  logic [31:0]                     data_length,
  input  logic [Tape_Num*pDATA_WIDTH-1:0] coef_flat,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [pADDR_WIDTH-1:0]          awaddr,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [pDATA_WIDTH-1:0]          wdata,
  output logic                            arvalid,
  input  logic                            arready,
  output logic [pADDR_WIDTH-1:0]          araddr,
  input  logic                            rvalid,
  output logic                            rready,
  input  logic [pDATA_WIDTH-1:0]          rdata,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [3:0]                      err_idx
);

  localparam int                POLL_W    = $clog2(POLL_MAX + 1);
  localparam logic [3:0]        LAST_TAP  = 4'(Tape_Num - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

  state_t                        r_state, w_state_nxt;
  logic [3:0]                    r_k, w_k_nxt;
  logic [POLL_W-1:0]             r_poll, w_poll_nxt;
  logic [31:0]                   r_len;
  logic [Tape_Num*pDATA_WIDTH-1:0] r_coef;
  logic                          w_busy_nxt, w_done_nxt, w_error_nxt;
  logic [3:0]                    w_err_idx_nxt;
  logic                          w_latch;

  logic                   w_req, w_we, w_ack;
  logic [pADDR_WIDTH-1:0] w_addr;
  logic [pDATA_WIDTH-1:0] w_wdata, w_rdata, w_coef_k;

  assign w_coef_k = r_coef[r_k*pDATA_WIDTH +: pDATA_WIDTH];

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_poll  <= '0;
      r_len   <= '0;
      r_coef  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      err_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_poll  <= w_poll_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      error   <= w_error_nxt;
      err_idx <= w_err_idx_nxt;
      if (w_latch) begin
        r_len  <= data_length;
        r_coef <= coef_flat;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_poll_nxt    = r_poll;
    w_busy_nxt    = busy;
    w_done_nxt    = done;
    w_error_nxt   = error;
    w_err_idx_nxt = err_idx;
    w_latch       = 1'b0;
    w_req         = 1'b0;
    w_we          = 1'b0;
    w_addr        = '0;
    w_wdata       = '0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch       = 1'b1;
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_err_idx_nxt = '0;
          w_k_nxt       = '0;
          w_poll_nxt    = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_WR_LEN;
        end
      end
      S_WR_LEN: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = pADDR_WIDTH'(ADDR_LEN);
        w_wdata = pDATA_WIDTH'(r_len);
        if (w_ack) w_state_nxt = S_WR_TAP;
      end
      S_WR_TAP: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = pADDR_WIDTH'(tap_addr(r_k));
        w_wdata = w_coef_k;
        if (w_ack) begin
          if (r_k == LAST_TAP) begin
            w_k_nxt     = '0;
            w_state_nxt = S_RD_TAP;
          end else begin
            w_k_nxt = r_k + 4'd1;
          end
        end
      end
      S_RD_TAP: begin
        w_req  = 1'b1;
        w_addr = pADDR_WIDTH'(tap_addr(r_k));
        if (w_ack) begin
          if (w_rdata != w_coef_k) begin
            w_error_nxt   = 1'b1;
            w_err_idx_nxt = r_k;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = S_ERR;
          end else if (r_k == LAST_TAP) begin
            w_k_nxt     = '0;
            w_state_nxt = S_WR_AP;
          end else begin
            w_k_nxt = r_k + 4'd1;
          end
        end
      end
      S_WR_AP: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = pADDR_WIDTH'(ADDR_AP_CTRL);
        w_wdata = pDATA_WIDTH'(1 << AP_START);
        if (w_ack) begin
          w_poll_nxt  = '0;
          w_state_nxt = S_POLL;
        end
      end
      S_POLL: begin
        w_req  = 1'b1;
        w_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
        if (w_ack) begin
          if (w_rdata[AP_DONE]) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else if (r_poll == POLL_LAST) begin
            // This read was the POLL_MAX-th without ap_done.
            w_error_nxt   = 1'b1;
            w_err_idx_nxt = ERR_TIMEOUT;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = S_ERR;
          end else begin
            w_poll_nxt = r_poll + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  axil_master_xact #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_xact (
    .clk        (axis_clk),
    .rst_n      (axis_rst_n),
    .req        (w_req),
    .we         (w_we),
    .addr       (w_addr),
    .wdata      (w_wdata),
    .ack        (w_ack),
    .rdata      (w_rdata),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_awaddr (awaddr),
    .axi_wvalid (wvalid),
    .axi_wready (wready),
    .axi_wdata  (wdata),
    .axi_arvalid(arvalid),
    .axi_arready(arready),
    .axi_araddr (araddr),
    .axi_rvalid (rvalid),
    .axi_rready (rready),
    .axi_rdata  (rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_fir_cfg_loader.sv
// +--------------------------------------------------------------------------+
// | tb_fir_cfg_loader : AXI-Lite slave model with transaction scoreboard     |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fir_cfg_loader;

  localparam int NT = 11;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int PM = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       data_length = 32'd600;
  logic [NT*32-1:0]  coef_flat = '0;
  logic              awvalid, wvalid, arvalid, rready;
  logic              awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [AW-1:0]     awaddr, araddr;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata = '0;
  logic              busy, done, error;
  logic [3:0]        err_idx;

  always #5 clk = ~clk;

  fir_cfg_loader #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT), .POLL_MAX(PM)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .start(start),
    .data_length(data_length), .coef_flat(coef_flat),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } xact_t;

  xact_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  int coefs [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  // slave model knobs and state
  int          aw_delay = 0, w_delay = 0, done_on = 2, corrupt_idx = -1;
  int          ap_writes = 0, viol = 0, busy_cycles = 0, poll_cnt = 0;
  int          aw_cnt = 0, w_cnt = 0;
  logic [31:0] mem [16];
  logic        aw_got = 0, w_got = 0, r_pend = 0, r_clr = 0;
  logic [11:0] g_awaddr = '0;
  logic [31:0] g_wdata = '0, rd_val = '0;
  logic        p_aw = 0, p_w = 0, p_ar = 0;
  logic [11:0] p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_compare(input xact_t got);
    xact_t e;
    if (exp_q.size() == 0) begin
      check("sb_extra_xact", 64'(got) | 64'h1_0000_0000_0000, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_xact", 64'(got), 64'(e));
    end
  endtask

  task automatic push_xact(input logic we, input int addr, input logic [31:0] data);
    xact_t x;
    x.we   = we;
    x.addr = 12'(addr);
    x.data = we ? data : 32'd0;
    exp_q.push_back(x);
  endtask

  task automatic push_expected(input int n_rd, input bit ap, input int n_polls);
    push_xact(1'b1, 'h10, data_length);
    for (int k = 0; k < NT; k++) push_xact(1'b1, 'h20 + 4*k, 32'(coefs[k]));
    for (int k = 0; k < n_rd; k++) push_xact(1'b0, 'h20 + 4*k, 32'd0);
    if (ap) push_xact(1'b1, 'h00, 32'd1);
    for (int i = 0; i < n_polls; i++) push_xact(1'b0, 'h00, 32'd0);
  endtask

  // Slave: inputs are set at the falling edge, so handshakes seen here are
  // exactly the ones committed at the following rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
        aw_got = 0; w_got = 0; r_pend = 0; r_clr = 0; aw_cnt = 0; w_cnt = 0;
        p_aw = 0; p_w = 0; p_ar = 0; poll_cnt = 0;
      end else begin
        if (p_aw && (!awvalid || awaddr !== p_awaddr)) viol++;
        if (p_w && (!wvalid || wdata !== p_wdata)) viol++;
        if (p_ar && (!arvalid || araddr !== p_araddr)) viol++;
        if (aw_got && awvalid) viol++;
        if (w_got && wvalid) viol++;
        if (r_clr) begin rvalid = 0; r_clr = 0; end
        if (r_pend) begin rvalid = 1; rdata = rd_val; r_pend = 0; end
        awready = awvalid && (aw_cnt >= aw_delay);
        wready  = wvalid && (w_cnt >= w_delay);
        arready = 1'b1;
        if (awvalid && !awready) aw_cnt++;
        if (wvalid && !wready) w_cnt++;
        if (awvalid && awready) begin aw_got = 1; g_awaddr = awaddr; aw_cnt = 0; end
        if (wvalid && wready) begin w_got = 1; g_wdata = wdata; w_cnt = 0; end
        if (aw_got && w_got) begin
          sb_compare({1'b1, g_awaddr, g_wdata});
          if (g_awaddr == 12'h000) begin ap_writes++; poll_cnt = 0; end
          else if (g_awaddr >= 12'h020) mem[(int'(g_awaddr) - 'h20) >> 2] = g_wdata;
          aw_got = 0; w_got = 0;
        end
        if (arvalid && arready) begin
          sb_compare({1'b0, araddr, 32'd0});
          if (araddr == 12'h000) begin
            poll_cnt++;
            rd_val = (done_on != 0 && poll_cnt >= done_on) ? 32'h2 : 32'h0;
          end else begin
            int idx;
            idx = (int'(araddr) - 'h20) >> 2;
            rd_val = (idx == corrupt_idx) ? 32'd24 : mem[idx];
          end
          r_pend = 1;
        end
        if (rvalid && rready) r_clr = 1;
        p_aw = awvalid && !awready; p_awaddr = awaddr;
        p_w  = wvalid && !wready;   p_wdata  = wdata;
        p_ar = arvalid && !arready; p_araddr = araddr;
        if (busy) busy_cycles++;
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
    check("busy_timeout", 64'(busy), 64'd0);
  endtask

  task automatic launch_and_wait(input int max_cyc);
    @(negedge clk);
    busy_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(max_cyc);
  endtask

  task automatic end_checks(input string name, input logic e_done, input logic e_err,
                            input logic [3:0] e_idx);
    repeat (5) @(negedge clk);
    check({name, "_status"}, {busy, done, error, err_idx}, {1'b0, e_done, e_err, e_idx});
    check({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_proto"}, 64'(viol), 64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {awvalid, wvalid, arvalid, rready, busy, done, error, err_idx}, 64'd0);
    check({name, "_addr"}, {awaddr, araddr}, 64'd0);
    check({name, "_wdata"}, 64'(wdata), 64'd0);
  endtask

  initial begin
    bit found;
    for (int k = 0; k < NT; k++) coef_flat[k*32 +: 32] = 32'(coefs[k]);
    for (int i = 0; i < 16; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // ideal slave
    push_expected(NT, 1, 2);
    launch_and_wait(300);
    check("ideal_cycles", 64'(busy_cycles), 64'd65);
    check("ideal_ap_writes", 64'(ap_writes), 64'd1);
    end_checks("ideal", 1'b1, 1'b0, 4'h0);

    // slow awready
    aw_delay = 3; w_delay = 0; ap_writes = 0;
    push_expected(NT, 1, 2);
    launch_and_wait(400);
    end_checks("aw_slow", 1'b1, 1'b0, 4'h0);

    // slow wready
    aw_delay = 0; w_delay = 3;
    push_expected(NT, 1, 2);
    launch_and_wait(400);
    end_checks("w_slow", 1'b1, 1'b0, 4'h0);
    w_delay = 0;

    // readback mismatch at tap 3
    corrupt_idx = 3; ap_writes = 0;
    push_expected(4, 0, 0);
    launch_and_wait(300);
    repeat (10) @(negedge clk);
    check("mismatch_ap_writes", 64'(ap_writes), 64'd0);
    end_checks("mismatch", 1'b0, 1'b1, 4'h3);
    corrupt_idx = -1;

    // ap_done never set
    done_on = 0;
    push_expected(NT, 1, PM);
    launch_and_wait(400);
    end_checks("timeout", 1'b0, 1'b1, 4'hF);
    done_on = 2;

    // second start during WR_TAP is ignored
    push_expected(NT, 1, 2);
    @(negedge clk);
    busy_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (awvalid && awaddr == 12'h024) found = 1;
      else @(negedge clk);
    end
    check("restart_reach_wr_tap", 64'(found), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(300);
    check("restart_cycles", 64'(busy_cycles), 64'd65);
    end_checks("restart", 1'b1, 1'b0, 4'h0);

    // async reset during RD_TAP with arvalid high
    push_expected(NT, 1, 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (arvalid && araddr == 12'h028) found = 1;
      else @(negedge clk);
    end
    check("rst_reach_rd_tap", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_expected(NT, 1, 2);
    launch_and_wait(300);
    check("post_rst_cycles", 64'(busy_cycles), 64'd65);
    end_checks("post_rst", 1'b1, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fir_cfg_loader.md
Name: fir_cfg_loader

Overview:
- AXI-Lite master that sits directly upstream of the fir block's configuration port and replaces manual host programming.
- On one `start` pulse it runs, in order:
  - writes data_length to 0x10;
  - writes Tape_Num coefficients to 0x20+4k;
  - reads every coefficient back and compares it;
  - writes ap_start (0x00 = 1);
  - polls 0x00 until ap_done.
- Reports busy/done/error to the surrounding control logic.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite data width
- Tape_Num, 11, number of coefficients (1..14)
- POLL_MAX, 1000000, maximum status reads before timeout

Ports:
- axis_clk  in  1  single clock
- axis_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; ignored while busy
- data_length  in  32  sampled at accepted start
- coef_flat  in  Tape_Num*32  coefficient k at bits [32k+31:32k]; sampled at accepted start
- awvalid  out  1  write-address valid
- awready  in  1  write-address ready
- awaddr  out  pADDR_WIDTH  write address
- wvalid  out  1  write-data valid
- wready  in  1  write-data ready
- wdata  out  pDATA_WIDTH  write data
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- araddr  out  pADDR_WIDTH  read address
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready
- rdata  in  pDATA_WIDTH  read data
- busy  out  1  sequence in progress
- done  out  1  sticky: sequence completed, ap_done seen
- error  out  1  sticky: readback mismatch or poll timeout
- err_idx  out  4  failing tap index; 4'hF = timeout

Behaviour:
- Reset (async, active-low) clears every output to 0, state to IDLE, and all counters to 0. Valids drop immediately even mid-transaction; there is no recovery of a pending slave handshake.
- States: IDLE -> WR_LEN -> WR_TAP -> RD_TAP -> WR_AP -> POLL -> DONE, plus ERR.
- IDLE: on start=1:
  - latch data_length and coef_flat;
  - clear done, error and err_idx;
  - k=0; busy=1; go to WR_LEN.
  - start in any other state has no effect.
- Write transaction (WR_LEN, WR_TAP, WR_AP):
  - awvalid and wvalid rise together, registered, in the cycle after state entry.
  - Each valid drops independently after its own handshake edge (valid&ready).
  - The transaction completes once both handshakes have occurred; the next transaction's valids appear no earlier than 1 cycle later.
  - awaddr/wdata stay stable while either valid is high.
- Read transaction (RD_TAP, POLL):
  - arvalid is held until the arready handshake.
  - rready rises the cycle after the AR handshake and is held until the rvalid handshake; rdata is captured on that edge.
  - rvalid arriving before rready is waited on, not lost.
- WR_TAP: address 0x20+4k, data coef k; k increments per completed write. After k=Tape_Num-1 completes, reset k=0 and go to RD_TAP.
- RD_TAP: compare the captured rdata with coef k.
  - Mismatch: error=1, err_idx=k, go to ERR; no ap_start write is issued.
  - After the last tap matches, go to WR_AP.
- WR_AP: address 0x00, data 32'h1.
- POLL:
  - Read 0x00 repeatedly, back-to-back, counting reads.
  - rdata[1]=1: go to DONE.
  - Count reaches POLL_MAX without ap_done: error=1, err_idx=4'hF, go to ERR.
- DONE: done=1, busy=0, return to IDLE (done stays until next accepted start).
- ERR: busy=0, return to IDLE (error and err_idx stay until next accepted start).
- Minimum latency with slaves always ready and rvalid the cycle after rready: exactly 2 cycles per write and 3 per read.

Decomposition:
- Package fir_cfg_pkg holds:
  - state enum;
  - address constants ADDR_AP_CTRL=0x00, ADDR_LEN=0x10, ADDR_TAP_BASE=0x20;
  - status bit positions AP_START=0, AP_DONE=1, AP_IDLE=2;
  - ERR_TIMEOUT=4'hF.
- One sub-module, axil_master_xact: a single-transaction engine.
  - Inputs: req, we, addr, wdata.
  - Outputs: ack, rdata.
  - Owns all AXI-Lite handshake logic; the top FSM only sequences.

Test Plan:
- Ideal slave (ready=1 always, rvalid 1 cycle after rready), data_length=600, coefs {0,-10,-9,23,56,63,56,23,-9,-10,0}, ap_done set on 2nd poll -> expected results:
  - exactly 13 writes in order 0x10, 0x20..0x48, 0x00;
  - 11 reads in order 0x20..0x48, then 2 reads of 0x00;
  - done=1, error=0;
  - cycle count = 13×2 + 13×3.
- awready delayed 3 cycles, wready immediate (and swapped case) -> wvalid high only until its own handshake; awaddr/wdata stable throughout; no duplicate write.
- Slave returns 24 for tap 3 -> error=1, err_idx=3; no write to 0x00 ever issued; busy=0.
- ap_done never set, POLL_MAX=8 -> exactly 8 reads of 0x00, then error=1, err_idx=4'hF.
- start pulsed again during WR_TAP -> ignored; sequence identical to first scenario.
- axis_rst_n low during RD_TAP with arvalid high -> all outputs 0 asynchronously; a new start after release runs the full sequence cleanly.
